// File: rtl/vec_unit_arbiter.sv
`timescale 1ns/1ps
// vec_unit_arbiter
// Round-robin arbiter that shares one fixed-latency vector unit between
// NUM_REQ requesters and routes each result back, tagged with its requester id.
//
// Ports
//   i_clk, i_rst_n          clock (rising edge), async active-low reset
//   i_req_valid/o_req_ready per-requester handshake; o_req_ready is one-hot
//   i_req_x/y/z             packed operands, requester k at [k*DATA_W +: DATA_W]
//   i_hold                  suppresses new grants, in-flight ops still drain
//   o_op_valid, o_op_x/y/z  registered operands issued to the shared unit
//   i_res_x/y/z             shared unit result, LATENCY cycles after o_op_valid
//   o_res_valid, o_res_id,
//   o_res_x/y/z             registered, routed result
//   o_inflight              issued but not yet returned op count
module vec_unit_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 7,
  parameter int DATA_W  = 27,
  localparam int ID_W   = $clog2(NUM_REQ),
  localparam int IF_W   = $clog2(LATENCY + 2) + 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  output logic [NUM_REQ-1:0]        o_req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_x,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_y,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_z,
  input  logic                      i_hold,
  output logic                      o_op_valid,
  output logic [DATA_W-1:0]         o_op_x,
  output logic [DATA_W-1:0]         o_op_y,
  output logic [DATA_W-1:0]         o_op_z,
  input  logic [DATA_W-1:0]         i_res_x,
  input  logic [DATA_W-1:0]         i_res_y,
  input  logic [DATA_W-1:0]         i_res_z,
  output logic                      o_res_valid,
  output logic [ID_W-1:0]           o_res_id,
  output logic [DATA_W-1:0]         o_res_x,
  output logic [DATA_W-1:0]         o_res_y,
  output logic [DATA_W-1:0]         o_res_z,
  output logic [IF_W-1:0]           o_inflight
);

  logic [ID_W-1:0]              r_rr_ptr;
  // Tag pipe: stage 0 is the o_op_valid cycle, stage LATENCY is the cycle
  // in which i_res_* carries that op's result.
  logic [LATENCY:0]             r_tag_v;
  logic [LATENCY:0][ID_W-1:0]   r_tag_id;
  logic [DATA_W-1:0]            r_op_x, r_op_y, r_op_z;
  logic                         r_res_valid;
  logic [ID_W-1:0]              r_res_id;
  logic [DATA_W-1:0]            r_res_x, r_res_y, r_res_z;
  logic [IF_W-1:0]              r_inflight;

  logic [NUM_REQ-1:0]           w_grant;
  logic [ID_W-1:0]              w_grant_idx;
  logic                         w_hs;
  logic                         w_tail_v;
  logic [DATA_W-1:0]            w_sel_x, w_sel_y, w_sel_z;
  logic [ID_W:0]                w_sum;
  logic [ID_W-1:0]              w_cand;

  // Search from rr_ptr upward with wrap; the first valid requester wins.
  always_comb begin
    w_grant     = '0;
    w_grant_idx = '0;
    w_hs        = 1'b0;
    w_sum       = '0;
    w_cand      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_sum = {1'b0, r_rr_ptr} + (ID_W+1)'(i);
      if (w_sum >= (ID_W+1)'(NUM_REQ))
        w_sum = w_sum - (ID_W+1)'(NUM_REQ);
      w_cand = w_sum[ID_W-1:0];
      if (!w_hs && i_req_valid[w_cand]) begin
        w_hs            = 1'b1;
        w_grant[w_cand] = 1'b1;
        w_grant_idx     = w_cand;
      end
    end
    if (i_hold || !i_rst_n) begin
      w_grant     = '0;
      w_grant_idx = '0;
      w_hs        = 1'b0;
    end
  end

  always_comb begin
    w_sel_x = '0;
    w_sel_y = '0;
    w_sel_z = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (w_grant[k]) begin
        w_sel_x = i_req_x[k*DATA_W +: DATA_W];
        w_sel_y = i_req_y[k*DATA_W +: DATA_W];
        w_sel_z = i_req_z[k*DATA_W +: DATA_W];
      end
    end
  end

  assign w_tail_v = r_tag_v[LATENCY];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rr_ptr    <= '0;
      r_tag_v     <= '0;
      r_tag_id    <= '0;
      r_op_x      <= '0;
      r_op_y      <= '0;
      r_op_z      <= '0;
      r_res_valid <= 1'b0;
      r_res_id    <= '0;
      r_res_x     <= '0;
      r_res_y     <= '0;
      r_res_z     <= '0;
      r_inflight  <= '0;
    end else begin
      r_tag_v  <= {r_tag_v[LATENCY-1:0], w_hs};
      r_tag_id <= {r_tag_id[LATENCY-1:0], w_grant_idx};

      if (w_hs) begin
        r_rr_ptr <= (w_grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + 1'b1;
        r_op_x   <= w_sel_x;
        r_op_y   <= w_sel_y;
        r_op_z   <= w_sel_z;
      end

      r_res_valid <= w_tail_v;
      if (w_tail_v) begin
        r_res_id <= r_tag_id[LATENCY];
        r_res_x  <= i_res_x;
        r_res_y  <= i_res_y;
        r_res_z  <= i_res_z;
      end

      // Retire on the edge that raises o_res_valid, so a continuous stream
      // settles at LATENCY+1 outstanding ops.
      case ({w_hs, w_tail_v})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  assign o_req_ready = w_grant;
  assign o_op_valid  = r_tag_v[0];
  assign o_op_x      = r_op_x;
  assign o_op_y      = r_op_y;
  assign o_op_z      = r_op_z;
  assign o_res_valid = r_res_valid;
  assign o_res_id    = r_res_id;
  assign o_res_x     = r_res_x;
  assign o_res_y     = r_res_y;
  assign o_res_z     = r_res_z;
  assign o_inflight  = r_inflight;

endmodule

// File: tb/tb_vec_unit_arbiter.sv
`timescale 1ns/1ps
module tb_vec_unit_arbiter;
  localparam int NR  = 4;
  localparam int L   = 7;
  localparam int W   = 27;
  localparam int IDW = $clog2(NR);
  localparam int IFW = $clog2(L + 2) + 1;

  localparam logic [W-1:0] ONE   = 27'h1FC0000;
  localparam logic [W-1:0] TWO   = 27'h2000000;
  localparam logic [W-1:0] THREE = 27'h2020000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_ready;
  logic [NR*W-1:0]   req_x = '0, req_y = '0, req_z = '0;
  logic              hold = 1'b0;
  logic              op_valid;
  logic [W-1:0]      op_x, op_y, op_z;
  logic [W-1:0]      res_x, res_y, res_z;
  logic              o_rv;
  logic [IDW-1:0]    o_rid;
  logic [W-1:0]      o_rx, o_ry, o_rz;
  logic [IFW-1:0]    inflight;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for the shared unit: result = operands + (1,2,3), LATENCY cycles
  // after o_op_valid; random junk whenever no op is due.
  logic         pv [L];
  logic [W-1:0] px [L], py [L], pz [L];
  logic [W-1:0] junk;
  always @(posedge clk) begin
    pv[0] <= op_valid; px[0] <= op_x; py[0] <= op_y; pz[0] <= op_z;
    for (int i = 1; i < L; i++) begin
      pv[i] <= pv[i-1]; px[i] <= px[i-1]; py[i] <= py[i-1]; pz[i] <= pz[i-1];
    end
    junk <= W'($urandom);
  end
  assign res_x = pv[L-1] ? px[L-1] + W'(1) : junk;
  assign res_y = pv[L-1] ? py[L-1] + W'(2) : ~junk;
  assign res_z = pv[L-1] ? pz[L-1] + W'(3) : junk ^ 27'h5A5A5A5;

  vec_unit_arbiter #(.NUM_REQ(NR), .LATENCY(L), .DATA_W(W)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_x(req_x), .i_req_y(req_y), .i_req_z(req_z),
    .i_hold(hold),
    .o_op_valid(op_valid), .o_op_x(op_x), .o_op_y(op_y), .o_op_z(op_z),
    .i_res_x(res_x), .i_res_y(res_y), .i_res_z(res_z),
    .o_res_valid(o_rv), .o_res_id(o_rid),
    .o_res_x(o_rx), .o_res_y(o_ry), .o_res_z(o_rz),
    .o_inflight(inflight)
  );

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '1; hold = 1'b0;
    repeat (10) @(negedge clk);
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    n_checks++; if (op_valid !== 1'b0) begin n_fail++; $display("FAIL reset_op_valid: got %b want 0", op_valid); end
    n_checks++; if (o_rv !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %b want 0", o_rv); end
    n_checks++; if (o_rid !== '0) begin n_fail++; $display("FAIL reset_res_id: got %0d want 0", o_rid); end
    n_checks++; if (inflight !== '0) begin n_fail++; $display("FAIL reset_inflight: got %0d want 0", inflight); end
    n_checks++; if (op_x !== '0 || o_rx !== '0) begin n_fail++; $display("FAIL reset_data: op_x %h res_x %h want 0", op_x, o_rx); end
    req_valid = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_single_op();
    int hs_neg, pulses, rcyc;
    logic [IDW-1:0] rid;
    logic [W-1:0] rx, ry, rz;
    @(negedge clk);
    req_valid = 4'b0010;
    req_x[1*W +: W] = ONE; req_y[1*W +: W] = TWO; req_z[1*W +: W] = THREE;
    #1;
    n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL single_ready: got %b want 0010", req_ready); end
    hs_neg = cyc;
    @(negedge clk);
    req_valid = '0;
    n_checks++; if (op_valid !== 1'b1) begin n_fail++; $display("FAIL single_op_valid: got %b want 1", op_valid); end
    n_checks++; if (op_x !== ONE || op_y !== TWO || op_z !== THREE) begin n_fail++; $display("FAIL single_operands: got %h %h %h want %h %h %h", op_x, op_y, op_z, ONE, TWO, THREE); end
    n_checks++; if (inflight !== 5'd1) begin n_fail++; $display("FAIL single_inflight: got %0d want 1", inflight); end
    @(negedge clk);
    n_checks++; if (op_valid !== 1'b0 || op_x !== ONE) begin n_fail++; $display("FAIL single_op_drop: valid %b x %h want 0 %h", op_valid, op_x, ONE); end
    pulses = 0; rcyc = -1; rid = '0; rx = '0; ry = '0; rz = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_rv) begin
        if (pulses == 0) begin rcyc = cyc; rid = o_rid; rx = o_rx; ry = o_ry; rz = o_rz; end
        pulses++;
      end
    end
    n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL single_pulses: got %0d want 1", pulses); end
    n_checks++; if (rcyc !== hs_neg + L + 2) begin n_fail++; $display("FAIL single_latency: got cycle %0d want %0d", rcyc, hs_neg + L + 2); end
    n_checks++; if (rid !== 2'd1) begin n_fail++; $display("FAIL single_id: got %0d want 1", rid); end
    n_checks++; if (rx !== ONE + 1 || ry !== TWO + 2 || rz !== THREE + 3) begin n_fail++; $display("FAIL single_result: got %h %h %h want %h %h %h", rx, ry, rz, ONE + 1, TWO + 2, THREE + 3); end
    n_checks++; if (o_rx !== ONE + 1) begin n_fail++; $display("FAIL single_res_hold: got %h want %h", o_rx, ONE + 1); end
    n_checks++; if (inflight !== '0) begin n_fail++; $display("FAIL single_drained: got %0d want 0", inflight); end
  endtask

  task automatic test_round_robin();
    int nres, first, last, maxif;
    logic [W-1:0] ex;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    nres = 0; first = -1; last = -1; maxif = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (int'(inflight) > maxif) maxif = int'(inflight);
      if (o_rv) begin
        ex = W'(((nres % 4) << 8) | nres) + W'(1);
        n_checks++; if (o_rid !== IDW'(nres % 4) || o_rx !== ex) begin n_fail++; $display("FAIL rr_result%0d: id %0d x %h want id %0d x %h", nres, o_rid, o_rx, nres % 4, ex); end
        if (first < 0) first = cyc;
        last = cyc;
        nres++;
      end
      if (i < 12) begin
        req_valid = '1;
        for (int k = 0; k < NR; k++) begin
          req_x[k*W +: W] = W'((k << 8) | i);
          req_y[k*W +: W] = W'(i);
          req_z[k*W +: W] = W'(k);
        end
        #1;
        n_checks++; if (req_ready !== NR'(1 << (i % 4))) begin n_fail++; $display("FAIL rr_grant%0d: got %b want %b", i, req_ready, NR'(1 << (i % 4))); end
      end else begin
        req_valid = '0;
      end
    end
    n_checks++; if (nres !== 12) begin n_fail++; $display("FAIL rr_count: got %0d want 12", nres); end
    n_checks++; if (last - first !== 11) begin n_fail++; $display("FAIL rr_throughput: span %0d want 11", last - first); end
    n_checks++; if (maxif !== L + 1) begin n_fail++; $display("FAIL rr_inflight_max: got %0d want %0d", maxif, L + 1); end
    n_checks++; if (inflight !== '0) begin n_fail++; $display("FAIL rr_drained: got %0d want 0", inflight); end
  endtask

  task automatic test_fairness();
    int nres;
    nres = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (o_rv) begin
        n_checks++; if (o_rid !== ((nres % 2) ? 2'd2 : 2'd0)) begin n_fail++; $display("FAIL fair_id%0d: got %0d want %0d", nres, o_rid, (nres % 2) ? 2 : 0); end
        nres++;
      end
      if (i < 6) begin
        req_valid = 4'b0101;
        #1;
        n_checks++; if (req_ready !== ((i % 2) ? 4'b0100 : 4'b0001)) begin n_fail++; $display("FAIL fair_grant%0d: got %b want %b", i, req_ready, (i % 2) ? 4'b0100 : 4'b0001); end
      end else begin
        req_valid = '0;
      end
    end
    n_checks++; if (nres !== 6) begin n_fail++; $display("FAIL fair_count: got %0d want 6", nres); end
    n_checks++; if (inflight !== '0) begin n_fail++; $display("FAIL fair_drained: got %0d want 0", inflight); end
  endtask

  task automatic test_hold();
    int hs [3];
    int eid [3];
    int nres;
    eid[0] = 3; eid[1] = 0; eid[2] = 1;
    nres = 0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (o_rv) begin
        if (nres < 3) begin
          n_checks++; if (o_rid !== IDW'(eid[nres]) || cyc !== hs[nres] + L + 2) begin n_fail++; $display("FAIL hold_result%0d: id %0d cycle %0d want id %0d cycle %0d", nres, o_rid, cyc, eid[nres], hs[nres] + L + 2); end
        end
        nres++;
      end
      req_valid = '1;
      if (i < 3) begin
        hold = 1'b0;
        #1;
        n_checks++; if (req_ready !== NR'(1 << eid[i])) begin n_fail++; $display("FAIL hold_issue%0d: got %b want %b", i, req_ready, NR'(1 << eid[i])); end
        hs[i] = cyc;
      end else begin
        if (i == 3) begin
          n_checks++; if (inflight !== 5'd3) begin n_fail++; $display("FAIL hold_inflight3: got %0d want 3", inflight); end
        end
        hold = 1'b1;
        #1;
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL hold_ready%0d: got %b want 0000", i, req_ready); end
      end
    end
    req_valid = '0; hold = 1'b0;
    n_checks++; if (nres !== 3) begin n_fail++; $display("FAIL hold_count: got %0d want 3", nres); end
    n_checks++; if (inflight !== '0) begin n_fail++; $display("FAIL hold_drained: got %0d want 0", inflight); end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0 || i == L + 1) begin
        if (i == L + 1) begin
          n_checks++; if (inflight !== 5'd1) begin n_fail++; $display("FAIL simul_before: got %0d want 1", inflight); end
        end
        req_valid = 4'b0100;
        #1;
        n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL simul_grant%0d: got %b want 0100", i, req_ready); end
      end else begin
        req_valid = '0;
      end
      if (i == L + 2) begin
        n_checks++; if (o_rv !== 1'b1 || inflight !== 5'd1) begin n_fail++; $display("FAIL simul_unchanged: res_valid %b inflight %0d want 1 1", o_rv, inflight); end
      end
    end
    n_checks++; if (inflight !== '0) begin n_fail++; $display("FAIL simul_drained: got %0d want 0", inflight); end
  endtask

  task automatic test_reset_midflight();
    int pulses;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req_valid = '1;
    end
    @(negedge clk);
    n_checks++; if (inflight !== 5'd4) begin n_fail++; $display("FAIL midrst_inflight4: got %0d want 4", inflight); end
    req_valid = 4'b1100;
    rst_n = 1'b0;
    #1;
    n_checks++; if (op_valid !== 1'b0 || op_x !== '0 || inflight !== '0 || o_rv !== 1'b0) begin n_fail++; $display("FAIL midrst_zero: op_valid %b op_x %h inflight %0d res_valid %b want all 0", op_valid, op_x, inflight, o_rv); end
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL midrst_ready: got %b want 0000", req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL midrst_first_grant: got %b want 0100", req_ready); end
    req_valid = '0;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (o_rv) pulses++;
    end
    n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL midrst_stale_results: got %0d want 0", pulses); end
    n_checks++; if (inflight !== '0 || o_rx !== '0) begin n_fail++; $display("FAIL midrst_after: inflight %0d res_x %h want 0 0", inflight, o_rx); end
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_round_robin();
    test_fairness();
    test_hold();
    test_simultaneous();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
